// File: rtl/bnn_pkg.sv
// bnn_pkg: shared state type and byte codes for the BNN command sequencer.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } seq_state_t;

    localparam logic [7:0] CMD_LOAD   = 8'hA1;
    localparam logic [7:0] CMD_START  = 8'hA2;
    localparam logic [7:0] CMD_READ   = 8'hA3;
    localparam logic [7:0] CMD_STATUS = 8'hA4;

    localparam logic [7:0] RSP_ACK = 8'h55;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    // Status byte layout: {5'b0, img_loaded, result_valid, err_flag}.
    function automatic logic [7:0] status_byte(input logic img_loaded,
                                               input logic result_valid,
                                               input logic err_flag);
        return {5'b0, img_loaded, result_valid, err_flag};
    endfunction

endpackage

// File: rtl/bnn_resp_reg.sv
// bnn_resp_reg: one-entry valid/ready holding register for the response byte.
module bnn_resp_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       accept
);

    assign accept = tx_valid && tx_ready;

    // Capture a response byte and hold it unchanged until the transmitter takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (push) begin
            tx_valid <= 1'b1;
            tx_data  <= push_data;
        end else if (accept) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bnn_cmd_sequencer.sv
// bnn_cmd_sequencer: parses UART command bytes, streams image bytes into the
// image buffer, launches inference and queues one response byte per command.
// Optional LOAD inactivity timeout: define BNN_SEQ_TIMEOUT_EN.
module bnn_cmd_sequencer
    import bnn_pkg::*;
#(
    parameter int IMG_BYTES      = 12,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         img_wr_en,
    output logic [$clog2(IMG_BYTES)-1:0] img_wr_addr,
    output logic [7:0]                   img_wr_data,
    output logic                         infer_start,
    input  logic                         infer_done,
    input  logic [3:0]                   infer_result,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic                         err_flag
);

    localparam int AW = $clog2(IMG_BYTES);

    seq_state_t    state;
    logic [AW-1:0] cnt;
    logic [3:0]    result_q;
    logic          img_loaded;
    logic          result_valid;
    logic          status_pending;

    logic          resp_push;
    logic [7:0]    resp_byte;
    logic          err_set;
    logic          status_rsp;
    logic          tx_accept;
    logic          last_byte;
    logic          load_timeout;

    assign last_byte = (cnt == AW'(IMG_BYTES - 1));

`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;

    // Count idle LOAD cycles since the last payload byte, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != ST_LOAD || rx_valid) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    assign load_timeout = (state == ST_LOAD) && !rx_valid &&
                          (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign load_timeout = 1'b0;
`endif

    // Decide whether this cycle queues a response, its byte, and any new error.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        resp_push  = 1'b0;
        resp_byte  = RSP_ERR;
        err_set    = 1'b0;
        status_rsp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD: begin
                        end
                        CMD_START: begin
                            if (!img_loaded) begin
                                resp_push = 1'b1;
                                err_set   = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            resp_push = 1'b1;
                            resp_byte = result_valid ? {4'h0, result_q} : RSP_ERR;
                        end
                        CMD_STATUS: begin
                            resp_push  = 1'b1;
                            resp_byte  = status_byte(img_loaded, result_valid, err_flag);
                            status_rsp = 1'b1;
                        end
                        default: begin
                            resp_push = 1'b1;
                            err_set   = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (rx_valid) begin
                    if (last_byte) begin
                        resp_push = 1'b1;
                        resp_byte = RSP_ACK;
                    end
                end else if (load_timeout) begin
                    resp_push = 1'b1;
                    err_set   = 1'b1;
                end
            end
            ST_RUN: begin
                if (infer_done) begin
                    resp_push = 1'b1;
                    resp_byte = RSP_ACK;
                end
                if (rx_valid) err_set = 1'b1;
            end
            ST_RESP: begin
                if (rx_valid) err_set = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Main sequencer FSM with registered outputs and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            result_q       <= 4'h0;
            img_loaded     <= 1'b0;
            result_valid   <= 1'b0;
            status_pending <= 1'b0;
            err_flag       <= 1'b0;
            busy           <= 1'b0;
            img_wr_en      <= 1'b0;
            img_wr_addr    <= '0;
            img_wr_data    <= 8'h00;
            infer_start    <= 1'b0;
        end else begin
            img_wr_en   <= 1'b0;
            infer_start <= 1'b0;

            // A new error in the same cycle as a STATUS accept keeps the flag set.
            if (err_set) begin
                err_flag <= 1'b1;
            end else if (status_pending && tx_accept) begin
                err_flag <= 1'b0;
            end

            if (status_rsp) begin
                status_pending <= 1'b1;
            end else if (tx_accept) begin
                status_pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        if (rx_data == CMD_LOAD) begin
                            state      <= ST_LOAD;
                            cnt        <= '0;
                            img_loaded <= 1'b0;
                        end else if (resp_push) begin
                            state <= ST_RESP;
                        end else begin
                            state       <= ST_RUN;
                            infer_start <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        img_wr_en   <= 1'b1;
                        img_wr_addr <= cnt;
                        img_wr_data <= rx_data;
                        cnt         <= cnt + AW'(1);
                        if (last_byte) begin
                            img_loaded   <= 1'b1;
                            result_valid <= 1'b0;
                            cnt          <= '0;
                            state        <= ST_RESP;
                        end
                    end else if (load_timeout) begin
                        state <= ST_RESP;
                    end
                end
                ST_RUN: begin
                    if (infer_done) begin
                        result_q     <= infer_result;
                        result_valid <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (tx_accept) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bnn_resp_reg u_resp_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (resp_push),
        .push_data (resp_byte),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .accept    (tx_accept)
    );

endmodule

// File: tb/tb_bnn_cmd_sequencer.sv
// tb_bnn_cmd_sequencer: directed and randomized bench for bnn_cmd_sequencer,
// checked against a command-level reference model of the protocol.
module tb_bnn_cmd_sequencer;

    localparam int IMG = 12;
`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 1_000_000;
`endif

    localparam logic [7:0] C_LOAD   = 8'hA1;
    localparam logic [7:0] C_START  = 8'hA2;
    localparam logic [7:0] C_READ   = 8'hA3;
    localparam logic [7:0] C_STATUS = 8'hA4;
    localparam logic [7:0] ACK      = 8'h55;
    localparam logic [7:0] ERR      = 8'hEE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       img_wr_en;
    logic [3:0] img_wr_addr;
    logic [7:0] img_wr_data;
    logic       infer_start;
    logic       infer_done;
    logic [3:0] infer_result;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err_flag;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the sequencer should remember between commands.
    logic       m_loaded = 1'b0;
    logic       m_rvalid = 1'b0;
    logic       m_err    = 1'b0;
    logic [3:0] m_result = 4'h0;
    logic [7:0] m_img    [IMG];
    logic [7:0] seen_img [IMG];
    int         wr_count    = 0;
    int         start_count = 0;

    bnn_cmd_sequencer #(
        .IMG_BYTES      (IMG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .img_wr_en    (img_wr_en),
        .img_wr_addr  (img_wr_addr),
        .img_wr_data  (img_wr_data),
        .infer_start  (infer_start),
        .infer_done   (infer_done),
        .infer_result (infer_result),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .err_flag     (err_flag)
    );

    always #5 clk = ~clk;

    // Image buffer and inference-core stand-ins.
    always @(posedge clk) begin
        if (img_wr_en === 1'b1) begin
            if (int'(img_wr_addr) < IMG) seen_img[img_wr_addr] = img_wr_data;
            wr_count++;
        end
        if (infer_start === 1'b1) start_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected response of a non-LOAD command issued in IDLE; updates the model.
    function automatic logic [7:0] model_cmd(input logic [7:0] c);
        logic [7:0] r;
        if (c == C_READ) begin
            r = m_rvalid ? {4'h0, m_result} : ERR;
        end else if (c == C_STATUS) begin
            r = {5'b0, m_loaded, m_rvalid, m_err};
            m_err = 1'b0;
        end else begin
            r = ERR;
            m_err = 1'b1;
        end
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_wr_en", tag),   img_wr_en,   0);
        check($sformatf("%s_wr_addr", tag), img_wr_addr, 0);
        check($sformatf("%s_wr_data", tag), img_wr_data, 0);
        check($sformatf("%s_start", tag),   infer_start, 0);
        check($sformatf("%s_tx_data", tag), tx_data,     0);
        check($sformatf("%s_tx_valid", tag), tx_valid,   0);
        check($sformatf("%s_busy", tag),    busy,        0);
        check($sformatf("%s_err", tag),     err_flag,    0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait a bounded number of cycles for a response, check it, let it be accepted.
    task automatic wait_resp(input string tag, input logic [7:0] exp, input int max_wait);
        int n = 0;
        while (tx_valid !== 1'b1 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_valid", tag), tx_valid, 1);
        check($sformatf("%s_data", tag), tx_data, exp);
        @(negedge clk);
        check($sformatf("%s_after", tag), {tx_valid, busy}, 2'b00);
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] c);
        logic [7:0] e;
        e = model_cmd(c);
        send_byte(c);
        wait_resp(tag, e, 0);
    endtask

    // Optionally send LOAD, then payload bytes [first,last) with per-byte write checks.
    task automatic load_seq(input string tag, input bit send_cmd, input int first,
                            input int last, input bit rnd);
        logic [7:0] b;
        if (send_cmd) begin
            send_byte(C_LOAD);
            m_loaded = 1'b0;
            check($sformatf("%s_busy", tag), busy, 1);
        end
        for (int i = first; i < last; i++) begin
            if (i > first) begin
                @(negedge clk);
                check($sformatf("%s_wr_gap%0d", tag, i), img_wr_en, 0);
            end
            b = rnd ? 8'($urandom) : 8'(i);
            m_img[i] = b;
            send_byte(b);
            check($sformatf("%s_wr%0d", tag, i), {img_wr_en, img_wr_addr, img_wr_data},
                  {1'b1, 4'(i), b});
        end
    endtask

    task automatic finish_load(input string tag);
        wait_resp(tag, ACK, 0);
        m_loaded = 1'b1;
        m_rvalid = 1'b0;
        for (int i = 0; i < IMG; i++)
            check($sformatf("%s_img%0d", tag, i), seen_img[i], m_img[i]);
    endtask

    task automatic run_inf(input string tag, input logic [3:0] res, input int delay);
        int s0;
        s0 = start_count;
        send_byte(C_START);
        check($sformatf("%s_start_hi", tag), {infer_start, busy}, 2'b11);
        @(negedge clk);
        check($sformatf("%s_start_lo", tag), infer_start, 0);
        repeat (delay) @(negedge clk);
        check($sformatf("%s_no_early", tag), tx_valid, 0);
        infer_result = res;
        infer_done   = 1'b1;
        @(negedge clk);
        infer_done   = 1'b0;
        infer_result = 4'($urandom);
        m_rvalid = 1'b1;
        m_result = res;
        wait_resp(tag, ACK, 0);
        check($sformatf("%s_pulses", tag), start_count - s0, 1);
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] b;
        int wc0;
        int n;

        rst_n        = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        infer_done   = 1'b0;
        infer_result = 4'h0;
        tx_ready     = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // START with no image: error response, no launch, sticky error until STATUS.
        e = model_cmd(C_START);
        send_byte(C_START);
        check("start_noimg_pulse", infer_start, 0);
        check("start_noimg_err", err_flag, 1);
        wait_resp("start_noimg", e, 0);
        do_cmd("status_err", C_STATUS);
        check("status_err_cleared", err_flag, 0);

        // Sequential image 0x00..0x0B, then STATUS.
        load_seq("load_seq", 1'b1, 0, IMG, 1'b0);
        finish_load("load_seq_done");
        do_cmd("status_loaded", C_STATUS);

        // infer_done outside RUN is ignored.
        infer_result = 4'h3;
        infer_done   = 1'b1;
        @(negedge clk);
        infer_done   = 1'b0;
        check("stray_done_idle", {tx_valid, busy}, 2'b00);
        do_cmd("read_noresult", C_READ);

        // Random image, inference with result 7 after 50 cycles, READ.
        load_seq("load_rnd", 1'b1, 0, IMG, 1'b1);
        finish_load("load_rnd_done");
        run_inf("run7", 4'h7, 50);
        do_cmd("read7", C_READ);

        // Back-pressure: response held 20 cycles; a byte sent meanwhile is dropped.
        wc0 = wr_count;
        e = model_cmd(C_READ);
        tx_ready = 1'b0;
        send_byte(C_READ);
        for (int k = 0; k < 20; k++) begin
            rx_data  = C_LOAD;
            rx_valid = (k == 5);
            @(negedge clk);
            check($sformatf("stall_hold%0d", k), {tx_valid, tx_data}, {1'b1, e});
        end
        rx_valid = 1'b0;
        m_err = 1'b1;
        check("stall_err", err_flag, 1);
        check("stall_busy", busy, 1);
        check("stall_no_write", wr_count - wc0, 0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("stall_release", {tx_valid, busy}, 2'b00);
        do_cmd("status_after_stall", C_STATUS);

        // STATUS accept and a new error in the same cycle: the error wins.
        e = model_cmd(C_STATUS);
        tx_ready = 1'b0;
        send_byte(C_STATUS);
        check("setwins_data", {tx_valid, tx_data}, {1'b1, e});
        repeat (3) @(negedge clk);
        tx_ready = 1'b1;
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        m_err = 1'b1;
        check("setwins_err", {tx_valid, err_flag}, 2'b01);
        do_cmd("setwins_status", C_STATUS);

        // Randomized command mix.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: do_cmd($sformatf("rnd%0d_read", it), C_READ);
                1: do_cmd($sformatf("rnd%0d_status", it), C_STATUS);
                2: begin
                    b = 8'($urandom);
                    while (b >= C_LOAD && b <= C_STATUS) b = 8'($urandom);
                    do_cmd($sformatf("rnd%0d_bad", it), b);
                end
                3: begin
                    if (m_loaded)
                        run_inf($sformatf("rnd%0d_run", it), 4'($urandom), $urandom_range(1, 30));
                    else
                        do_cmd($sformatf("rnd%0d_start", it), C_START);
                end
                4: begin
                    load_seq($sformatf("rnd%0d_load", it), 1'b1, 0, IMG, 1'b1);
                    finish_load($sformatf("rnd%0d_load_done", it));
                end
                default: repeat ($urandom_range(0, 3)) @(negedge clk);
            endcase
        end

`ifdef BNN_SEQ_TIMEOUT_EN
        // Three payload bytes then silence: error response after TMO idle cycles.
        load_seq("tmo", 1'b1, 0, 3, 1'b1);
        n = 0;
        while (tx_valid !== 1'b1 && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TMO);
        m_err = 1'b1;
        wait_resp("tmo_rsp", ERR, 0);
        check("tmo_err", err_flag, 1);
        do_cmd("tmo_start", C_START);
`else
        // Without the timeout, a stalled LOAD just waits and then completes.
        load_seq("slow", 1'b1, 0, 3, 1'b1);
        repeat (200) @(negedge clk);
        n = 0;
        check("slow_waiting", {tx_valid, busy}, 2'b01);
        load_seq("slow", 1'b0, 3, IMG, 1'b1);
        finish_load("slow_done");
`endif

        // Unknown command, then reset in the middle of a LOAD.
        do_cmd("unknown_3c", 8'h3C);
        load_seq("abort", 1'b1, 0, 5, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        m_loaded = 1'b0;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_result = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd("status_after_reset", C_STATUS);
        do_cmd("read_after_reset", C_READ);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bnn_cmd_sequencer.md
# bnn_cmd_sequencer

Command sequencer between the UART receive/transmit path and the BNN inference core. Parses single-byte commands from the UART receiver, streams image bytes into the image buffer, launches inference, and queues one response byte per command toward the UART transmitter. It is the only block that drives the image buffer write port and the inference start strobe.

## Interface
- `IMG_BYTES`, default 12: number of image bytes per LOAD (≥2).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clocks between LOAD payload bytes (≥1).
- `clk`  in  1  system clock; one clock domain only.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  received byte; valid only when `rx_valid` is high.
- `rx_valid`  in  1  single-cycle pulse, one per received byte.
- `img_wr_en`  out  1  image buffer write strobe.
- `img_wr_addr`  out  $clog2(IMG_BYTES)  image buffer byte address.
- `img_wr_data`  out  8  image buffer write data.
- `infer_start`  out  1  single-cycle inference launch pulse.
- `infer_done`  in  1  single-cycle pulse from the core; `infer_result` is valid in the same cycle.
- `infer_result`  in  4  class index.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts when `tx_valid && tx_ready`.
- `busy`  out  1  high in any state other than IDLE.
- `err_flag`  out  1  sticky protocol error.

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE, on `rx_valid`, decodes the command byte:
  - 0xA1 LOAD: clear the byte counter and enter LOAD.
  - 0xA2 START: only if `img_loaded`, pulse `infer_start` and enter RUN. Otherwise respond 0xEE and set `err_flag`.
  - 0xA3 READ: respond `{4'h0, result_q}` if `result_valid`, else 0xEE.
  - 0xA4 STATUS: respond `{5'b0, img_loaded, result_valid, err_flag}`, then clear `err_flag` when that response is accepted.
  - Any other byte: respond 0xEE and set `err_flag`.
- LOAD:
  - Each `rx_valid` writes `rx_data` at address = counter, then increments the counter.
  - After byte IMG_BYTES-1: set `img_loaded`, clear `result_valid`, respond 0x55.
- RUN: on `infer_done`, latch `infer_result` into `result_q`, set `result_valid`, respond 0x55.
- RESP: drive `tx_valid` with the stored byte. On handshake, go to IDLE.
- Bytes arriving in RUN or RESP are dropped and set `err_flag`.
- An `infer_done` pulse outside RUN is ignored.
- Simultaneous STATUS-clear and a new error in the same cycle: set wins.
- Every new LOAD clears `img_loaded` on entry. An aborted LOAD therefore leaves `img_loaded` = 0.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, `result_q` 0, `img_loaded` = `result_valid` = `err_flag` = 0.
- `rx_valid` in cycle N gives `img_wr_en`, `img_wr_addr`, and `img_wr_data` registered in cycle N+1, for exactly one cycle.
- START byte in cycle N gives `infer_start` high in cycle N+1 only.
- A response is decided in cycle N; `tx_valid` rises in N+1.
- `tx_data` is stable while `tx_valid` && !`tx_ready`.
- Back-to-back: after a handshake in cycle M, a command byte in cycle M+1 is accepted.
- `busy` is registered with the state (it rises the cycle after the command byte).
- `rst_n` asserted mid-operation returns everything to reset values immediately. Partial image contents in the buffer are not cleared.

## Configuration
- `BNN_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in LOAD, is cleared on each payload byte, and saturates.
  - On reaching TIMEOUT_CYCLES without a byte: abort LOAD, set `err_flag`, respond 0xEE.
- Undefined: LOAD waits indefinitely, and no timeout counter is synthesized.

## Structure
- Package `bnn_pkg` holds:
  - the state enum `seq_state_t`;
  - command codes `CMD_LOAD`, `CMD_START`, `CMD_READ`, `CMD_STATUS`;
  - response codes `RSP_ACK` = 0x55 and `RSP_ERR` = 0xEE.
- One natural sub-module, `bnn_resp_reg`: a one-entry valid/ready holding register for `tx_data`/`tx_valid`.

## Test plan
- Reset, then LOAD with IMG_BYTES=12 bytes 0x00..0x0B: 12 writes at addresses 0..11 with matching data, then `tx_data` = 0x55. STATUS then returns 0x04.
- START before any LOAD: `tx_data` = 0xEE, no `infer_start`, `err_flag` = 1. STATUS returns 0x01, and `err_flag` reads 0 afterwards.
- LOAD, START, `infer_done` with result 7 after 50 cycles: one `infer_start` pulse, then 0x55. READ returns 0x07.
- `tx_ready` held low for 20 cycles during a response: `tx_data` and `tx_valid` stay constant. A byte sent meanwhile sets `err_flag` and is not decoded.
- Unknown byte 0x3C: response 0xEE. Then `rst_n` pulled low in the middle of a LOAD: all outputs return to 0, and STATUS returns 0x00.
- With `BNN_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=100: LOAD plus 3 bytes, then silence gives 0xEE at 100 idle cycles. A subsequent START returns 0xEE.
